// File: rtl/control_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired fetch/decode/execute sequencer driving the DataPath
//               control strobes, memory strobes and ALU operation select.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
    parameter logic [4:0] PC_INC_CODE = 5'b11111,
    parameter logic [4:0] ADD_CODE    = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        ConOut,
    output logic        HiIn,
    output logic        LoIn,
    output logic        ZIn,
    output logic        PCIn,
    output logic        MDRIn,
    output logic        MARIn,
    output logic        YIn,
    output logic        OPortIn,
    output logic        IRIn,
    output logic        HiOut,
    output logic        LoOut,
    output logic        ZHiOut,
    output logic        ZLoOut,
    output logic        PCOut,
    output logic        MDROut,
    output logic        IPortOut,
    output logic        COut,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        RIn,
    output logic        ROut,
    output logic        BAOut,
    output logic        Conin,
    output logic        memread,
    output logic        memwrite,
    output logic [4:0]  ALUCode,
    output logic        run
);

    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_T7   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CLS_LD     = 4'd0,
        CLS_LDI    = 4'd1,
        CLS_ST     = 4'd2,
        CLS_RALU   = 4'd3,
        CLS_IMM    = 4'd4,
        CLS_MULDIV = 4'd5,
        CLS_NEGNOT = 4'd6,
        CLS_BR     = 4'd7,
        CLS_JR     = 4'd8,
        CLS_IN     = 4'd9,
        CLS_OUT    = 4'd10,
        CLS_MFHI   = 4'd11,
        CLS_MFLO   = 4'd12,
        CLS_NOP    = 4'd13,
        CLS_HALT   = 4'd14
    } op_class_t;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t cls;
        case (op)
            5'b00000: cls = CLS_LD;
            5'b00001: cls = CLS_LDI;
            5'b00010: cls = CLS_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: cls = CLS_RALU;
            5'b01100, 5'b01101, 5'b01110: cls = CLS_IMM;
            5'b01111, 5'b10000: cls = CLS_MULDIV;
            5'b10001, 5'b10010: cls = CLS_NEGNOT;
            5'b10011: cls = CLS_BR;
            5'b10100: cls = CLS_JR;
            5'b10101: cls = CLS_IN;
            5'b10110: cls = CLS_OUT;
            5'b10111: cls = CLS_MFHI;
            5'b11000: cls = CLS_MFLO;
            5'b11010: cls = CLS_HALT;
            default:  cls = CLS_NOP;
        endcase
        return cls;
    endfunction

    function automatic logic [4:0] imm_code(input logic [4:0] op);
        logic [4:0] code;
        case (op)
            5'b01100: code = 5'b00011;
            5'b01101: code = 5'b00101;
            5'b01110: code = 5'b00110;
            default:  code = 5'b00000;
        endcase
        return code;
    endfunction

    function automatic state_t last_state(input op_class_t cls);
        state_t st;
        case (cls)
            CLS_RALU, CLS_IMM, CLS_LDI: st = ST_T5;
            CLS_MULDIV, CLS_BR:         st = ST_T6;
            CLS_LD, CLS_ST:             st = ST_T7;
            CLS_NEGNOT:                 st = ST_T4;
            default:                    st = ST_T3;
        endcase
        return st;
    endfunction

    state_t     r_state;
    logic [4:0] r_op;

    logic [4:0] w_op;
    op_class_t  w_cls_ir;
    op_class_t  w_cls;
    state_t     w_last;
    logic       w_unused;

    // T3 decodes straight from ir; later states use the opcode captured in T3
    assign w_op     = (r_state == ST_T3) ? ir[31:27] : r_op;
    assign w_cls_ir = classify(ir[31:27]);
    assign w_cls    = classify(w_op);
    assign w_last   = last_state(w_cls);
    assign w_unused = ^ir[26:0];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= ST_T0;
            r_op    <= 5'b00000;
        end else begin
            case (r_state)
                ST_T0: r_state <= ST_T1;
                ST_T1: r_state <= ST_T2;
                // nop skips execute entirely, so it is recognised while IR loads
                ST_T2: r_state <= (w_cls_ir == CLS_NOP) ? ST_T0 : ST_T3;
                ST_T3: begin
                    r_op <= ir[31:27];
                    if (w_cls == CLS_HALT)
                        r_state <= ST_HALT;
                    else if (w_last == ST_T3)
                        r_state <= ST_T0;
                    else
                        r_state <= ST_T4;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= (r_state == w_last) ? ST_T0
                                                        : state_t'(r_state + 4'd1);
            endcase
        end
    end

    always_comb begin
        HiIn     = 1'b0;
        LoIn     = 1'b0;
        ZIn      = 1'b0;
        PCIn     = 1'b0;
        MDRIn    = 1'b0;
        MARIn    = 1'b0;
        YIn      = 1'b0;
        OPortIn  = 1'b0;
        IRIn     = 1'b0;
        HiOut    = 1'b0;
        LoOut    = 1'b0;
        ZHiOut   = 1'b0;
        ZLoOut   = 1'b0;
        PCOut    = 1'b0;
        MDROut   = 1'b0;
        IPortOut = 1'b0;
        COut     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        RIn      = 1'b0;
        ROut     = 1'b0;
        BAOut    = 1'b0;
        Conin    = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        ALUCode  = 5'b00000;
        run      = 1'b0;
        if (!clear) begin
            run = (r_state != ST_HALT);
            case (r_state)
                ST_T0: begin
                    PCOut = 1'b1; MARIn = 1'b1; ZIn = 1'b1; ALUCode = PC_INC_CODE;
                end
                ST_T1: begin
                    ZLoOut = 1'b1; PCIn = 1'b1; memread = 1'b1; MDRIn = 1'b1;
                end
                ST_T2: begin
                    MDROut = 1'b1; IRIn = 1'b1;
                end
                ST_T3: begin
                    case (w_cls)
                        CLS_RALU, CLS_IMM: begin Grb = 1'b1; ROut = 1'b1; YIn = 1'b1; end
                        CLS_LDI, CLS_LD, CLS_ST: begin Grb = 1'b1; BAOut = 1'b1; YIn = 1'b1; end
                        CLS_MULDIV: begin Gra = 1'b1; ROut = 1'b1; YIn = 1'b1; end
                        CLS_NEGNOT: begin
                            Grb = 1'b1; ROut = 1'b1; ZIn = 1'b1; ALUCode = w_op;
                        end
                        CLS_BR:   begin Gra = 1'b1; ROut = 1'b1; Conin = 1'b1; end
                        CLS_JR:   begin Gra = 1'b1; ROut = 1'b1; PCIn = 1'b1; end
                        CLS_IN:   begin IPortOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
                        CLS_OUT:  begin Gra = 1'b1; ROut = 1'b1; OPortIn = 1'b1; end
                        CLS_MFHI: begin HiOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
                        CLS_MFLO: begin LoOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
                        default: ;
                    endcase
                end
                ST_T4: begin
                    case (w_cls)
                        CLS_RALU: begin
                            Grc = 1'b1; ROut = 1'b1; ZIn = 1'b1; ALUCode = w_op;
                        end
                        CLS_MULDIV: begin
                            Grb = 1'b1; ROut = 1'b1; ZIn = 1'b1; ALUCode = w_op;
                        end
                        CLS_IMM: begin
                            COut = 1'b1; ZIn = 1'b1; ALUCode = imm_code(w_op);
                        end
                        CLS_LDI, CLS_LD, CLS_ST: begin
                            COut = 1'b1; ZIn = 1'b1; ALUCode = ADD_CODE;
                        end
                        CLS_NEGNOT: begin ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
                        CLS_BR:     begin PCOut = 1'b1; YIn = 1'b1; end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (w_cls)
                        CLS_RALU, CLS_IMM, CLS_LDI: begin
                            ZLoOut = 1'b1; Gra = 1'b1; RIn = 1'b1;
                        end
                        CLS_MULDIV:     begin ZLoOut = 1'b1; LoIn = 1'b1; end
                        CLS_LD, CLS_ST: begin ZLoOut = 1'b1; MARIn = 1'b1; end
                        CLS_BR: begin
                            COut = 1'b1; ZIn = 1'b1; ALUCode = ADD_CODE;
                        end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    case (w_cls)
                        CLS_MULDIV: begin ZHiOut = 1'b1; HiIn = 1'b1; end
                        CLS_LD:     begin memread = 1'b1; MDRIn = 1'b1; end
                        CLS_ST:     begin Gra = 1'b1; ROut = 1'b1; MDRIn = 1'b1; end
                        CLS_BR: begin
                            ZLoOut = ConOut;
                            PCIn   = ConOut;
                        end
                        default: ;
                    endcase
                end
                ST_T7: begin
                    case (w_cls)
                        CLS_LD: begin MDROut = 1'b1; Gra = 1'b1; RIn = 1'b1; end
                        CLS_ST: memwrite = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
